// File: rtl/arb_pkg.sv
// Shared constants and helpers for the parametrised priority arbiter.
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // OR-accumulates bit positions, so the result is only meaningful for zero- or one-hot input.
    function automatic logic [4:0] onehotToIdx(input logic [31:0] oneHot);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oneHot[i]) idx = idx | i[4:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/param_priority_arbiter_pick.sv
// Combinational lowest-index-first picker; in round-robin mode the search starts just after i_ptr.
module priority_pick
    import arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic            i_mode,
    input  logic [IDXW-1:0] i_ptr,
    output logic [N-1:0]    o_pick,
    output logic            o_found
);

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    logic [IDXW-1:0] w_start;
    logic [N-1:0]    w_rot;
    logic [N-1:0]    w_rotPick;

    always_comb begin
        w_start = '0;
        if (i_mode == MODE_RR && i_ptr != LAST) w_start = i_ptr + IDXW'(1);
    end

    // Rotate so the first candidate sits at bit 0, isolate the lowest set bit, then rotate back.
    assign w_rot     = N'({i_req, i_req} >> w_start);
    assign w_rotPick = w_rot & (~w_rot + N'(1));
    assign o_pick    = N'(({w_rotPick, w_rotPick} << w_start) >> N);
    assign o_found   = |i_req;

endmodule

// File: rtl/param_priority_arbiter.sv
// N-requester arbiter with registered one-hot grant, fixed/round-robin modes and bounded grant hold.
module param_priority_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mode_rr,
    input  logic            hold,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            hold_expired
);

    localparam int              HCW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

    logic [N-1:0]    r_grant;
    logic            r_valid;
    logic [IDXW-1:0] r_gidx;
    logic [IDXW-1:0] r_ptr;
    logic [HCW-1:0]  r_holdCnt;
    logic            r_holdExpired;

    logic            w_curReq;
    logic            w_holding;
    logic            w_atLimit;
    logic            w_keep;
    logic            w_expire;
    logic [N-1:0]    w_pickReq;
    logic [N-1:0]    w_pick;
    logic            w_found;
    logic [31:0]     w_pickWide;
    logic [IDXW-1:0] w_pickIdx;

    assign w_curReq  = |(r_grant & req);
    assign w_holding = (|r_grant) & hold & w_curReq;
    assign w_atLimit = (MAX_HOLD != 0) && (r_holdCnt == HOLD_LAST);
    assign w_keep    = w_holding & ~w_atLimit;
    assign w_expire  = w_holding & w_atLimit;

    // A force-released holder is excluded from this round so someone else gets a turn.
    assign w_pickReq = w_expire ? (req & ~r_grant) : req;

    priority_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .i_req   (w_pickReq),
        .i_mode  (mode_rr),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_pickWide        = '0;
        w_pickWide[N-1:0] = w_pick;
    end

    assign w_pickIdx = IDXW'(onehotToIdx(w_pickWide));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant       <= '0;
            r_valid       <= 1'b0;
            r_gidx        <= '0;
            r_ptr         <= IDXW'(N - 1);
            r_holdCnt     <= '0;
            r_holdExpired <= 1'b0;
        end else begin
            r_holdExpired <= w_expire;
            if (w_keep) begin
                r_holdCnt <= r_holdCnt + HCW'(1);
            end else begin
                r_grant   <= w_pick;
                r_valid   <= w_found;
                r_gidx    <= w_pickIdx;
                r_holdCnt <= '0;
                if (w_found) r_ptr <= w_pickIdx;
            end
        end
    end

    assign grant        = r_grant;
    assign grant_valid  = r_valid;
    assign grant_idx    = r_gidx;
    assign hold_expired = r_holdExpired;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed scoreboard bench for param_priority_arbiter (N=4, MAX_HOLD=3).
module tb_param_priority_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 3;
    localparam int IDXW     = 2;

    typedef struct {
        logic [N-1:0]    grant;
        logic            valid;
        logic [IDXW-1:0] idx;
        logic            expired;
        string           tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic            modeRr = 1'b0;
    logic            hold = 1'b0;
    logic [N-1:0]    grant;
    logic            grantValid;
    logic [IDXW-1:0] grantIdx;
    logic            holdExpired;

    exp_t sbQueue[$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   grantTally[N];

    param_priority_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .mode_rr      (modeRr),
        .hold         (hold),
        .grant        (grant),
        .grant_valid  (grantValid),
        .grant_idx    (grantIdx),
        .hold_expired (holdExpired)
    );

    always #5 clk = ~clk;

    function automatic logic [IDXW-1:0] idxOf(input logic [N-1:0] oh);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) r = i[IDXW-1:0];
        end
        return r;
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sbQueue.size() == 0) begin
            checkCount++;
            errorCount++;
            $error("[TB] FAIL scoreboard_empty: observed no entry, expected one");
            return;
        end
        e = sbQueue.pop_front();
        checkCount++;
        assert (grant === e.grant) else begin
            errorCount++;
            $error("[TB] FAIL %s grant: observed %b expected %b", e.tag, grant, e.grant);
        end
        checkCount++;
        assert (grantValid === e.valid) else begin
            errorCount++;
            $error("[TB] FAIL %s grant_valid: observed %b expected %b", e.tag, grantValid, e.valid);
        end
        checkCount++;
        assert (grantIdx === e.idx) else begin
            errorCount++;
            $error("[TB] FAIL %s grant_idx: observed %0d expected %0d", e.tag, grantIdx, e.idx);
        end
        checkCount++;
        assert (holdExpired === e.expired) else begin
            errorCount++;
            $error("[TB] FAIL %s hold_expired: observed %b expected %b", e.tag, holdExpired, e.expired);
        end
    endtask

    // Drive one cycle of inputs, record what the arbiter should show after the edge, then compare.
    task automatic applyStimulus(input logic rstV, input logic [N-1:0] reqV, input logic modeV,
                                 input logic holdV, input logic [N-1:0] expGrant,
                                 input logic expExpired, input string tag);
        exp_t e;
        @(negedge clk);
        rst    = rstV;
        req    = reqV;
        modeRr = modeV;
        hold   = holdV;
        e.grant   = expGrant;
        e.valid   = |expGrant;
        e.idx     = idxOf(expGrant);
        e.expired = expExpired;
        e.tag     = tag;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [N-1:0] rrSeq [8];
        rrSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "reset");

        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b0, "fixed_1010");
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, "fixed_1000");
        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, "fixed_none");
        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, 4'b0010, 1'b0, "fixed_low_a");
        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, 4'b0010, 1'b0, "fixed_low_b");
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, "fixed_ptr3");

        for (int i = 0; i < N; i++) grantTally[i] = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, rrSeq[c], 1'b0, $sformatf("rr_fair_%0d", c));
            for (int i = 0; i < N; i++) if (grant[i]) grantTally[i]++;
        end
        for (int i = 0; i < N; i++) begin
            checkCount++;
            assert (grantTally[i] == 2) else begin
                errorCount++;
                $error("[TB] FAIL rr_tally_%0d: observed %0d expected 2", i, grantTally[i]);
            end
        end

        applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b0, "rr_wrap_a");
        applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0, 4'b0100, 1'b0, "rr_wrap_b");
        applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0, 4'b0001, 1'b0, "rr_wrap_c");

        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "idle");
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b0, "hold_1");
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b0, "hold_2");
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, 4'b0001, 1'b0, "hold_3");
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, 4'b0010, 1'b1, "hold_expire");
        applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, 4'b0010, 1'b0, "hold_new_owner");
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "holder_drops");

        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, "idle2");
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "lone_1");
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "lone_2");
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "lone_3");
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, "lone_expire");
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "lone_regrant");
        applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0, "lone_keep");

        applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, "mid_reset");
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, "post_reset_rr");
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0, "post_reset_rr2");

        checkCount++;
        assert (sbQueue.size() == 0) else begin
            errorCount++;
            $error("[TB] FAIL scoreboard_drain: observed %0d entries expected 0", sbQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
